wt_mem_arbiter: RTL
===================

Name: wt_mem_arbiter

Overview:
- Shares the single memory request channel of the write-through cache subsystem between the I$ and the D$ miss/write paths.
- Fair round-robin arbitration, a registered one-entry output stage, and per-requester outstanding-transaction counters with back-pressure.
- Demultiplexes return-valid strobes to the originating cache.
- Drain control for fence/flush sequencing.
- Sits between the wt_icache/wt_dcache memory ports and the memory adapter (AXI or L1.5).

Parameters:
- PayloadWidth, 128, width of the opaque request payload (address, size, data, tid packed by the caches).
- MaxOutstanding, 4, max in-flight transactions per requester (must be ≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset: one clock; reset is asynchronous and active-low.
- icache_data_req_i  in  1  I$ request; held high until acked.
- icache_data_ack_o  out  1  single-cycle acceptance pulse to I$.
- icache_data_i  in  PayloadWidth  I$ request payload.
- dcache_data_req_i  in  1  D$ request; held high until acked.
- dcache_data_ack_o  out  1  single-cycle acceptance pulse to D$.
- dcache_data_i  in  PayloadWidth  D$ request payload.
- mem_req_valid_o  out  1  output stage holds a request.
- mem_req_ready_i  in  1  downstream accepts.
- mem_req_src_o  out  1  0 = I$, 1 = D$.
- mem_req_data_o  out  PayloadWidth  registered payload.
- mem_rtrn_valid_i  in  1  a transaction completed.
- mem_rtrn_src_i  in  1  source of the completed transaction.
- icache_rtrn_vld_o  out  1  return strobe to I$.
- dcache_rtrn_vld_o  out  1  return strobe to D$.
- drain_i  in  1  block new grants (level).
- drained_o  out  1  nothing in flight and output stage empty.
- icache_outstanding_o  out  CntW  I$ in-flight count; CntW = $clog2(MaxOutstanding+1).
- dcache_outstanding_o  out  CntW  D$ in-flight count.

Behaviour:
- Reset values:
  - mem_req_valid_o = 0; mem_req_src_o = 0; mem_req_data_o = 0.
  - Both acks = 0; both rtrn_vld = 0.
  - Both counters = 0; drained_o = 1.
  - last_grant = 1 (D$), so I$ wins the first tie.
- Eligibility: requester is eligible if req_i = 1, its counter < MaxOutstanding, and drain_i = 0.
- Slot: the output stage is "free" if mem_req_valid_o = 0, or if mem_req_valid_o = 1 and mem_req_ready_i = 1 this cycle. This allows back-to-back issue at one request per cycle.
- Grant: occurs only when the slot is free and at least one requester is eligible.
  - One eligible requester: grant it.
  - Both eligible: grant the requester other than last_grant.
- On grant, the same cycle:
  - Assert the winner's ack (combinational, one cycle).
  - Next edge: capture payload into mem_req_data_o, set mem_req_src_o to the winner, set mem_req_valid_o, update last_grant to the winner, increment the winner's counter.
- Latency: request → ack in the same cycle if the slot is free; ack → mem_req_valid_o one cycle.
- Hold: while mem_req_valid_o = 1 and mem_req_ready_i = 0, mem_req_data_o and mem_req_src_o are stable. No ack is issued.
- Ready without a new grant: mem_req_valid_o deasserts next edge.
- Return path:
  - icache_rtrn_vld_o = mem_rtrn_valid_i & ~mem_rtrn_src_i (combinational).
  - dcache_rtrn_vld_o = mem_rtrn_valid_i & mem_rtrn_src_i (combinational).
  - The selected counter decrements at the next edge.
- Simultaneous grant and return for the same requester: counter unchanged.
- Counter saturation:
  - A return while the counter = 0 leaves the counter at 0; simulation-only assertion error.
  - The counter never exceeds MaxOutstanding, guaranteed by the eligibility rule.
- At-limit blocking: a requester at MaxOutstanding is skipped. If the other is eligible, it wins regardless of last_grant.
- drain_i:
  - Blocks new grants only.
  - A request already in the output stage still completes.
  - Returns still decrement.
- drained_o = (both counters = 0) & ~mem_req_valid_o, registered-state based, combinational from state.
- Requester dropping req_i without ack: ignored (protocol violation; assertion in simulation).
- Reset asserted mid-transfer: all state clears immediately; in-flight returns after reset are treated as underflow (saturate).

Decomposition:
- wt_cache_pkg gains:
  - localparams MEM_SRC_ICACHE = 1'b0 and MEM_SRC_DCACHE = 1'b1.
  - A packed struct mem_arb_req_t {logic src; logic [PayloadWidth-1:0] data} once the width is fixed.
- One natural sub-module: wt_mem_arb_cnt (saturating up/down counter with limit flag), instantiated twice.
- Arbitration, output register and routing stay in the top.

Test Plan:
- I$ alone, ready = 1, 3 requests with payloads 0x11/0x22/0x33 → 3 acks on consecutive cycles; mem_req_data_o sequence 0x11, 0x22, 0x33 with src = 0; icache_outstanding_o reaches 3.
- Both requesting continuously, ready = 1, MaxOutstanding = 4, returns immediate → grants alternate I, D, I, D… starting with I$ after reset.
- D$ reaches 4 outstanding with no returns while I$ also requests → D$ receives no 5th ack; I$ granted every free slot; one D$ return → D$ granted on the next free slot.
- ready_i = 0 for 5 cycles after a grant → valid, data and src stable all 5 cycles; no further acks; after ready = 1, next grant in that same cycle.
- drain_i = 1 with 2 I$ outstanding and one in the output stage → output stage completes, no new acks; drained_o rises the cycle after the 3rd return.
- Same-cycle D$ grant and D$ return with count 2 → count stays 2; dcache_rtrn_vld_o pulses once.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared definitions for the write-through cache subsystem memory path.
// Source encodings and the request record used between the caches and the memory arbiter.
package wt_cache_pkg;

    localparam logic MEM_SRC_ICACHE = 1'b0;
    localparam logic MEM_SRC_DCACHE = 1'b1;

    localparam int unsigned MEM_ARB_PAYLOAD_W = 128;

    typedef struct packed {
        logic                         src;
        logic [MEM_ARB_PAYLOAD_W-1:0] data;
    } mem_arb_req_t;

endpackage

// File: rtl/wt_mem_arb_cnt.sv
// Saturating up/down in-flight counter for one arbiter requester.
// o_at_limit tells the arbiter to stop granting this requester.
module wt_mem_arb_cnt #(
    parameter int unsigned MaxCount = 4,
    localparam int unsigned CntW    = $clog2(MaxCount + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_inc,
    input  logic            i_dec,
    output logic [CntW-1:0] o_cnt,
    output logic            o_at_limit
);

    localparam logic [CntW-1:0] LIMIT = CntW'(MaxCount);

    logic [CntW-1:0] r_cnt;

    // A simultaneous increment and decrement cancel; both ends saturate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && r_cnt != LIMIT) begin
            r_cnt <= r_cnt + CntW'(1);
        end else if (i_dec && !i_inc && r_cnt != '0) begin
            r_cnt <= r_cnt - CntW'(1);
        end
    end

    assign o_cnt      = r_cnt;
    assign o_at_limit = (r_cnt == LIMIT);

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(i_dec && !i_inc && r_cnt == '0))
        else $error("wt_mem_arb_cnt: return with no transaction in flight");

endmodule

// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter sharing the memory request channel between I$ and D$,
// with a registered output stage, per-requester in-flight limits and drain control.
module wt_mem_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned PayloadWidth   = 128,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    icache_data_req_i,
    output logic                    icache_data_ack_o,
    input  logic [PayloadWidth-1:0] icache_data_i,
    input  logic                    dcache_data_req_i,
    output logic                    dcache_data_ack_o,
    input  logic [PayloadWidth-1:0] dcache_data_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_req_src_o,
    output logic [PayloadWidth-1:0] mem_req_data_o,
    input  logic                    mem_rtrn_valid_i,
    input  logic                    mem_rtrn_src_i,
    output logic                    icache_rtrn_vld_o,
    output logic                    dcache_rtrn_vld_o,
    input  logic                    drain_i,
    output logic                    drained_o,
    output logic [CntW-1:0]         icache_outstanding_o,
    output logic [CntW-1:0]         dcache_outstanding_o
);

    logic                    r_valid;
    logic                    r_src;
    logic [PayloadWidth-1:0] r_data;
    logic                    r_last_grant;

    logic w_slot_free;
    logic w_i_at_limit;
    logic w_d_at_limit;
    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_i;
    logic w_grant_d;

    // Gating with rst_ni keeps the acks quiet while reset is held.
    assign w_slot_free = rst_ni & (~r_valid | mem_req_ready_i);
    assign w_i_elig    = icache_data_req_i & ~w_i_at_limit & ~drain_i;
    assign w_d_elig    = dcache_data_req_i & ~w_d_at_limit & ~drain_i;

    assign w_grant_i = w_slot_free & w_i_elig &
                       (~w_d_elig | (r_last_grant == MEM_SRC_DCACHE));
    assign w_grant_d = w_slot_free & w_d_elig &
                       (~w_i_elig | (r_last_grant == MEM_SRC_ICACHE));

    assign icache_data_ack_o = w_grant_i;
    assign dcache_data_ack_o = w_grant_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid      <= 1'b0;
            r_src        <= MEM_SRC_ICACHE;
            r_data       <= '0;
            r_last_grant <= MEM_SRC_DCACHE;
        end else if (w_grant_i || w_grant_d) begin
            r_valid      <= 1'b1;
            r_src        <= w_grant_d ? MEM_SRC_DCACHE : MEM_SRC_ICACHE;
            r_data       <= w_grant_d ? dcache_data_i : icache_data_i;
            r_last_grant <= w_grant_d ? MEM_SRC_DCACHE : MEM_SRC_ICACHE;
        end else if (mem_req_ready_i) begin
            r_valid      <= 1'b0;
        end
    end

    assign mem_req_valid_o = r_valid;
    assign mem_req_src_o   = r_src;
    assign mem_req_data_o  = r_data;

    assign icache_rtrn_vld_o = mem_rtrn_valid_i & (mem_rtrn_src_i == MEM_SRC_ICACHE);
    assign dcache_rtrn_vld_o = mem_rtrn_valid_i & (mem_rtrn_src_i == MEM_SRC_DCACHE);

    wt_mem_arb_cnt #(
        .MaxCount (MaxOutstanding)
    ) u_cnt_icache (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_inc      (w_grant_i),
        .i_dec      (icache_rtrn_vld_o),
        .o_cnt      (icache_outstanding_o),
        .o_at_limit (w_i_at_limit)
    );

    wt_mem_arb_cnt #(
        .MaxCount (MaxOutstanding)
    ) u_cnt_dcache (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_inc      (w_grant_d),
        .i_dec      (dcache_rtrn_vld_o),
        .o_cnt      (dcache_outstanding_o),
        .o_at_limit (w_d_at_limit)
    );

    assign drained_o = (icache_outstanding_o == '0) & (dcache_outstanding_o == '0) & ~r_valid;

    // Requests must be held until acknowledged.
    a_icache_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (icache_data_req_i && !icache_data_ack_o) |=> icache_data_req_i)
        else $error("wt_mem_arbiter: I$ dropped request before ack");

    a_dcache_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dcache_data_req_i && !dcache_data_ack_o) |=> dcache_data_req_i)
        else $error("wt_mem_arbiter: D$ dropped request before ack");

endmodule
